// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - command encodings, mode-register decode, error bit indices and timing minima
// Ports: none (package). Timing minima exist only when SDRAM_TIMING_CHK_EN is defined.
package sdr_pkg;

    // {ras,cas,we} with cs already known to be low
    typedef enum logic [3:0] {
        CMD_LMR       = 4'b0000,
        CMD_REFRESH   = 4'b0001,
        CMD_PRECHARGE = 4'b0010,
        CMD_ACTIVE    = 4'b0011,
        CMD_WRITE     = 4'b0100,
        CMD_READ      = 4'b0101,
        CMD_TERMINATE = 4'b0110,
        CMD_NOP       = 4'b0111
    } sdr_cmd_e;

    localparam int ERR_CLOSED_BANK = 0;
    localparam int ERR_ACT_OPEN    = 1;
    localparam int ERR_REF_OPEN    = 2;
    localparam int ERR_TIMING      = 3;

    localparam logic [1:0] CL2 = 2'd2;
    localparam logic [1:0] CL3 = 2'd3;

`ifdef SDRAM_TIMING_CHK_EN
    localparam logic [2:0] T_RCD = 3'd3;
    localparam logic [2:0] T_RP  = 3'd3;
    localparam logic [2:0] T_RFC = 3'd7;
`endif

    function automatic logic [3:0] decode_bl(input logic [2:0] code);
        case (code)
            3'b001:  return 4'd2;
            3'b010:  return 4'd4;
            3'b011:  return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [1:0] decode_cl(input logic [2:0] code);
        return (code == 3'd2) ? CL2 : CL3;
    endfunction

endpackage

// File: rtl/sdr_sdram_responder_if.sv
// rtl/sdr_sdram_responder_if.sv - SDRAM controller pin bundle shared by controller and responder
// Signals: sdram_cle/cs/ras/cas/we/dqm/ba/a/dqi driven by master (controller);
//          sdram_dqo/sdram_dq_oe driven by slave (responder).
interface sdr_sdram_responder_if;
    logic        sdram_cle;
    logic        sdram_cs;
    logic        sdram_ras;
    logic        sdram_cas;
    logic        sdram_we;
    logic        sdram_dqm;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic [31:0] sdram_dqi;
    logic [31:0] sdram_dqo;
    logic        sdram_dq_oe;

    modport master (
        output sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we,
               sdram_dqm, sdram_ba, sdram_a, sdram_dqi,
        input  sdram_dqo, sdram_dq_oe
    );

    modport slave (
        input  sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we,
               sdram_dqm, sdram_ba, sdram_a, sdram_dqi,
        output sdram_dqo, sdram_dq_oe
    );
endinterface

// File: rtl/sdr_rd_pipe.sv
// rtl/sdr_rd_pipe.sv - read data/valid delay line with runtime CAS latency select (2 or 3)
// Ports: clk, rst (sync active-low), i_en (shift enable, low = hold), i_cl (CAS latency),
//        i_vld/i_data (beat issued this cycle), o_vld/o_data (registered beat CL cycles later).
module sdr_rd_pipe
    import sdr_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [1:0]    i_cl,
    input  logic          i_vld,
    input  logic [DW-1:0] i_data,
    output logic          o_vld,
    output logic [DW-1:0] o_data
);
    logic [2:0]    r_vld;
    logic [DW-1:0] r_data [3];
    logic          w_sel_vld;
    logic [DW-1:0] w_sel_data;

    // Issue edge loads stage 0 and the output register adds the final cycle,
    // so CL2 taps stage 1 and CL3 taps stage 2.
    assign w_sel_vld  = (i_cl == CL2) ? r_vld[1]  : r_vld[2];
    assign w_sel_data = (i_cl == CL2) ? r_data[1] : r_data[2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld  <= '0;
            o_vld  <= 1'b0;
            o_data <= '0;
        end else if (i_en) begin
            r_vld     <= {r_vld[1:0], i_vld};
            r_data[0] <= i_data;
            r_data[1] <= r_data[0];
            r_data[2] <= r_data[1];
            o_vld     <= w_sel_vld;
            o_data    <= w_sel_vld ? w_sel_data : '0;
        end
    end
endmodule

// File: rtl/sdr_sdram_responder.sv
// rtl/sdr_sdram_responder.sv - single-rank SDR SDRAM device model: command decode, bank table, bursts, array
// Ports: clk, rst (sync active-low), bus (sdr_sdram_responder_if.slave pin bundle),
//        err[3:0] sticky flags {timing, refresh/lmr with open bank, act to open bank, access to closed bank}.
// Config: SDRAM_TIMING_CHK_EN builds per-bank tRCD/tRP and global tRFC gap checks driving err[3].
module sdr_sdram_responder
    import sdr_pkg::*;
#(
    parameter int MEM_AW   = 10,
    parameter int COL_BITS = 8,
    parameter int ROW_BITS = 13,
    parameter int CL_RST   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    sdr_sdram_responder_if.slave bus,
    output logic [3:0]           err
);
    logic [3:0]          r_open;
    logic [ROW_BITS-1:0] r_row [4];
    logic [1:0]          r_cl;
    logic [3:0]          r_bl;
    logic [3:0]          r_err;

    logic                r_bst_act;
    logic                r_bst_rd;
    logic [1:0]          r_bst_ba;
    logic [ROW_BITS-1:0] r_bst_row;
    logic [COL_BITS-1:0] r_bst_col;
    logic [2:0]          r_bst_beat;
    logic [3:0]          r_bst_bl;

    logic [31:0]         r_mem [2**MEM_AW];

    sdr_cmd_e            w_cmd;
    logic                w_cmd_vld;
    logic                w_is_act, w_is_pre, w_is_ref, w_is_lmr, w_is_rd, w_is_wr, w_is_term;
    logic                w_rw, w_start, w_stop, w_cont;
    logic [COL_BITS-1:0] w_mask, w_ccol;
    logic                w_acc, w_acc_rd;
    logic [MEM_AW-1:0]   w_acc_idx;
    logic [31:0]         w_rd_data;
    logic                w_tim_viol;

    assign w_cmd_vld = bus.sdram_cle & ~bus.sdram_cs;
    assign w_cmd     = sdr_cmd_e'({1'b0, bus.sdram_ras, bus.sdram_cas, bus.sdram_we});
    assign w_is_act  = w_cmd_vld && (w_cmd == CMD_ACTIVE);
    assign w_is_pre  = w_cmd_vld && (w_cmd == CMD_PRECHARGE);
    assign w_is_ref  = w_cmd_vld && (w_cmd == CMD_REFRESH);
    assign w_is_lmr  = w_cmd_vld && (w_cmd == CMD_LMR);
    assign w_is_rd   = w_cmd_vld && (w_cmd == CMD_READ);
    assign w_is_wr   = w_cmd_vld && (w_cmd == CMD_WRITE);
    assign w_is_term = w_cmd_vld && (w_cmd == CMD_TERMINATE);

    assign w_rw    = w_is_rd | w_is_wr;
    assign w_start = w_rw & r_open[bus.sdram_ba];
    assign w_stop  = w_rw | w_is_term | w_is_pre;
    // cle low freezes the burst, so continuation also needs cle
    assign w_cont  = bus.sdram_cle & r_bst_act & ~w_stop;

    // Sequential wrap: the beat offset stays inside the BL-aligned column block
    assign w_mask = COL_BITS'(r_bst_bl - 4'd1);
    assign w_ccol = (r_bst_col & ~w_mask) | ((r_bst_col + COL_BITS'(r_bst_beat)) & w_mask);

    always_comb begin
        w_acc     = 1'b0;
        w_acc_rd  = 1'b0;
        w_acc_idx = '0;
        if (w_start) begin
            w_acc     = 1'b1;
            w_acc_rd  = w_is_rd;
            w_acc_idx = MEM_AW'({bus.sdram_ba, r_row[bus.sdram_ba], bus.sdram_a[COL_BITS-1:0]});
        end else if (w_cont) begin
            w_acc     = 1'b1;
            w_acc_rd  = r_bst_rd;
            w_acc_idx = MEM_AW'({r_bst_ba, r_bst_row, w_ccol});
        end
    end

    // Read happens at issue, before this edge's write, so an overlapping write is not seen
    assign w_rd_data = r_mem[w_acc_idx];

    always_ff @(posedge clk) begin
        if (rst && w_acc && !w_acc_rd && !bus.sdram_dqm)
            r_mem[w_acc_idx] <= bus.sdram_dqi;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_open     <= '0;
            r_cl       <= 2'(CL_RST);
            r_bl       <= 4'd1;
            r_err      <= '0;
            r_bst_act  <= 1'b0;
            r_bst_rd   <= 1'b0;
            r_bst_ba   <= '0;
            r_bst_row  <= '0;
            r_bst_col  <= '0;
            r_bst_beat <= '0;
            r_bst_bl   <= 4'd1;
        end else begin
            if (w_is_act) begin
                if (r_open[bus.sdram_ba])
                    r_err[ERR_ACT_OPEN] <= 1'b1;
                r_open[bus.sdram_ba] <= 1'b1;
                r_row[bus.sdram_ba]  <= ROW_BITS'(bus.sdram_a);
            end
            if (w_is_pre) begin
                if (bus.sdram_a[10])
                    r_open <= '0;
                else
                    r_open[bus.sdram_ba] <= 1'b0;
            end
            if ((w_is_ref || w_is_lmr) && (|r_open))
                r_err[ERR_REF_OPEN] <= 1'b1;
            if (w_is_lmr) begin
                r_bl <= decode_bl(bus.sdram_a[2:0]);
                r_cl <= decode_cl(bus.sdram_a[6:4]);
            end
            if (w_rw && !r_open[bus.sdram_ba])
                r_err[ERR_CLOSED_BANK] <= 1'b1;
            if (w_tim_viol)
                r_err[ERR_TIMING] <= 1'b1;

            // Beat 0 is served on the command edge; the counter tracks beats 1..BL-1
            if (w_start) begin
                r_bst_act  <= (r_bl != 4'd1);
                r_bst_rd   <= w_is_rd;
                r_bst_ba   <= bus.sdram_ba;
                r_bst_row  <= r_row[bus.sdram_ba];
                r_bst_col  <= bus.sdram_a[COL_BITS-1:0];
                r_bst_beat <= 3'd1;
                r_bst_bl   <= r_bl;
            end else if (w_stop) begin
                r_bst_act <= 1'b0;
            end else if (w_cont) begin
                r_bst_beat <= r_bst_beat + 3'd1;
                if ({1'b0, r_bst_beat} == r_bst_bl - 4'd1)
                    r_bst_act <= 1'b0;
            end
        end
    end

`ifdef SDRAM_TIMING_CHK_EN
    // Counters hold cycles since the last event, saturating at 7 (reset = long ago)
    logic [2:0] r_rcd_cnt [4];
    logic [2:0] r_rp_cnt  [4];
    logic [2:0] r_rfc_cnt;

    always_comb begin
        w_tim_viol = 1'b0;
        if (w_rw && (r_rcd_cnt[bus.sdram_ba] < T_RCD))
            w_tim_viol = 1'b1;
        if (w_is_act && (r_rp_cnt[bus.sdram_ba] < T_RP))
            w_tim_viol = 1'b1;
        if (w_cmd_vld && (w_cmd != CMD_NOP) && (r_rfc_cnt < T_RFC))
            w_tim_viol = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < 4; b++) begin
                r_rcd_cnt[b] <= 3'd7;
                r_rp_cnt[b]  <= 3'd7;
            end
            r_rfc_cnt <= 3'd7;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (r_rcd_cnt[b] != 3'd7) r_rcd_cnt[b] <= r_rcd_cnt[b] + 3'd1;
                if (r_rp_cnt[b]  != 3'd7) r_rp_cnt[b]  <= r_rp_cnt[b]  + 3'd1;
            end
            if (r_rfc_cnt != 3'd7) r_rfc_cnt <= r_rfc_cnt + 3'd1;
            if (w_is_act)
                r_rcd_cnt[bus.sdram_ba] <= 3'd1;
            if (w_is_pre) begin
                if (bus.sdram_a[10]) begin
                    for (int b = 0; b < 4; b++) r_rp_cnt[b] <= 3'd1;
                end else begin
                    r_rp_cnt[bus.sdram_ba] <= 3'd1;
                end
            end
            if (w_is_ref)
                r_rfc_cnt <= 3'd1;
        end
    end
`else
    assign w_tim_viol = 1'b0;
`endif

    sdr_rd_pipe #(.DW(32)) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_en   (bus.sdram_cle),
        .i_cl   (r_cl),
        .i_vld  (w_acc & w_acc_rd),
        .i_data (w_rd_data),
        .o_vld  (bus.sdram_dq_oe),
        .o_data (bus.sdram_dqo)
    );

    assign err = r_err;
endmodule

// File: tb/tb_sdr_sdram_responder.sv
// tb/tb_sdr_sdram_responder.sv - scoreboard bench for sdr_sdram_responder
module tb_sdr_sdram_responder;
    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_NOP = 4'b0111;
`ifdef SDRAM_TIMING_CHK_EN
    localparam logic EXP_ERR3 = 1'b1;
`else
    localparam logic EXP_ERR3 = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] err;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    exp_t       m_e;

    sdr_sdram_responder_if ifc();

    sdr_sdram_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc),
        .err (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, want, cyc);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [31:0] d, input logic m);
        {ifc.sdram_cs, ifc.sdram_ras, ifc.sdram_cas, ifc.sdram_we} = c;
        ifc.sdram_ba  = b;
        ifc.sdram_a   = a;
        ifc.sdram_dqi = d;
        ifc.sdram_dqm = m;
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        repeat (n) drive(C_NOP, 2'd0, 13'd0, 32'd0, 1'b0);
    endtask

    task automatic wr4(input logic [1:0] b, input logic [12:0] col, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                       input logic [3:0] m);
        drive(C_WR,  b,    col,   d0, m[0]);
        drive(C_NOP, 2'd0, 13'd0, d1, m[1]);
        drive(C_NOP, 2'd0, 13'd0, d2, m[2]);
        drive(C_NOP, 2'd0, 13'd0, d3, m[3]);
    endtask

    task automatic rd4(input logic [1:0] b, input logic [12:0] col, input int cl,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
        int t;
        t = cyc + 1;
        exp_q.push_back('{t + cl,     e0});
        exp_q.push_back('{t + cl + 1, e1});
        exp_q.push_back('{t + cl + 2, e2});
        exp_q.push_back('{t + cl + 3, e3});
        drive(C_RD, b, col, 32'd0, 1'b0);
    endtask

    // Monitor: every dq_oe beat must match the head of the queue in cycle and data
    always @(negedge clk) begin
        if (ifc.sdram_dq_oe === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got dq_oe=1 data %h at cyc %0d, want dq_oe=0",
                         ifc.sdram_dqo, cyc);
            end else begin
                m_e = exp_q.pop_front();
                if (m_e.cyc != cyc || m_e.data !== ifc.sdram_dqo) begin
                    bad++;
                    $display("FAIL beat: got %h at cyc %0d want %h at cyc %0d",
                             ifc.sdram_dqo, cyc, m_e.data, m_e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            m_e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL beat_missing: got dq_oe=0 at cyc %0d want %h", cyc, m_e.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        ifc.sdram_cle = 1'b1;
        {ifc.sdram_cs, ifc.sdram_ras, ifc.sdram_cas, ifc.sdram_we} = 4'b1111;
        ifc.sdram_dqm = 1'b0;
        ifc.sdram_ba  = '0;
        ifc.sdram_a   = '0;
        ifc.sdram_dqi = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dq_oe", 32'(ifc.sdram_dq_oe), 32'd0);
        chk("rst_dqo",   ifc.sdram_dqo,        32'd0);
        chk("rst_err",   32'(err),             32'd0);
        rst = 1'b1;

        drive(C_LMR, 2'd0, 13'h022, 32'd0, 1'b0);   // CL2, BL4
        drive(C_ACT, 2'd0, 13'd5,   32'd0, 1'b0);
        nop(2);
        wr4(2'd0, 13'h010, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0000);
        nop(1);
        rd4(2'd0, 13'h010, 2, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        nop(6);

        wr4(2'd0, 13'h00C, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 4'b0000);
        nop(1);
        rd4(2'd0, 13'h00E, 2, 32'hB2, 32'hB3, 32'hB0, 32'hB1);
        nop(6);

        wr4(2'd0, 13'h020, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000);
        wr4(2'd0, 13'h020, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 4'b0010);
        nop(1);
        rd4(2'd0, 13'h020, 2, 32'hD0, 32'hFFFFFFFF, 32'hD2, 32'hD3);
        nop(6);
        chk("err_clean", 32'(err[2:0]), 32'd0);

        drive(C_RD, 2'd2, 13'h010, 32'd0, 1'b0);
        chk("err_closed_bank", 32'(err[2:0]), 32'b001);
        nop(5);
        drive(C_ACT, 2'd0, 13'd5, 32'd0, 1'b0);
        chk("err_act_open", 32'(err[2:0]), 32'b011);
        drive(C_REF, 2'd0, 13'd0, 32'd0, 1'b0);
        chk("err_ref_open", 32'(err[2:0]), 32'b111);

        rst = 1'b0;
        nop(2);
        rst = 1'b1;
        chk("err_after_reset", 32'(err), 32'd0);
        drive(C_RD, 2'd1, 13'd0, 32'd0, 1'b0);
        chk("err_closed_b1", 32'(err[2:0]), 32'b001);
        drive(C_ACT, 2'd0, 13'd5, 32'd0, 1'b0);
        nop(3);

        // CL3 BL1 reads on four consecutive cycles, then reset lands on the second beat
        t = cyc + 1;
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{t + 3 + k, 32'hA0 + 32'(k)});
        for (int k = 0; k < 4; k++)
            drive(C_RD, 2'd0, 13'h010 + 13'(k), 32'd0, 1'b0);
        #1;
        exp_q.delete();
        rst = 1'b0;
        drive(C_NOP, 2'd0, 13'd0, 32'd0, 1'b0);
        chk("midrst_dq_oe", 32'(ifc.sdram_dq_oe), 32'd0);
        chk("midrst_err",   32'(err),             32'd0);
        rst = 1'b1;
        nop(4);

        drive(C_ACT, 2'd1, 13'd0, 32'd0, 1'b0);
        drive(C_WR,  2'd1, 13'd0, 32'h5, 1'b0);
        chk("timing_err3",  32'(err[3]),   32'(EXP_ERR3));
        chk("timing_errlo", 32'(err[2:0]), 32'd0);
        nop(8);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
